// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : VGA raster timing (640x480@60 default) with frame-locked
//                  snapshot of market data for tear-free display.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic [7:0] buy_price_in,
  input  logic [7:0] sell_price_in,
  input  logic [7:0] trade_count_in,
  input  logic [7:0] spread_in,
  input  logic       halt_in,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic [7:0] buy_price,
  output logic [7:0] sell_price,
  output logic [7:0] trade_count,
  output logic [7:0] spread,
  output logic       halt_signal
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_wrap;
  logic       boundary;
  logic       video_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;

  // Decodes use the next counter values so every registered output lines up
  // with the h_cnt/v_cnt presented in the same cycle.
  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    boundary  = h_wrap && (v_cnt == V_LAST);
    h_nxt     = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt     = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    video_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hsync_nxt = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
      buy_price   <= 8'd0;
      sell_price  <= 8'd0;
      trade_count <= 8'd0;
      spread      <= 8'd0;
      halt_signal <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      video_on    <= video_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      frame_start <= boundary;
      // Market data is captured only at the frame boundary so a frame never tears.
      if (boundary) begin
        frame_cnt   <= frame_cnt + 8'd1;
        buy_price   <= buy_price_in;
        sell_price  <= sell_price_in;
        trade_count <= trade_count_in;
        spread      <= spread_in;
        halt_signal <= halt_in;
      end
    end
  end

endmodule

`default_nettype wire
